lfsr_checker: RTL and testbench

//   Receive-side checker for the LFSR pseudo-random stream. It samples WIDTH-bit words,

---
 rtl/lfsr_checker.sv | 115 +++++++++++
 tb/tb_lfsr_checker.sv | 123 ++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising receive checker for an LFSR word stream
module lfsr_checker #(
    parameter int WIDTH        = 8,
    parameter int LOCK_MATCHES = 4,
    parameter int UNLOCK_ERRS  = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clr,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] sample_count
);
    localparam int MW = $clog2(LOCK_MATCHES + 1);
    localparam int BW = $clog2(UNLOCK_ERRS + 1);
    localparam logic [WIDTH-1:0] TAPS = (WIDTH == 8) ? WIDTH'(8'hB8)
                                      : WIDTH'((1 << (WIDTH - 1)) | (1 << (WIDTH - 3)));

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pred_q, pred_d;
    logic             has_ref_q, has_ref_d;
    logic [MW-1:0]    match_run_q, match_run_d;
    logic [BW-1:0]    bad_run_q, bad_run_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] smp_cnt_q, smp_cnt_d;
    logic [WIDTH-1:0] exp_w;

    assign exp_w        = {pred_q[WIDTH-2:0], ^(pred_q & TAPS)};
    assign locked       = (state_q == LOCKED);
    assign err          = err_q;
    assign err_count    = err_cnt_q;
    assign sample_count = smp_cnt_q;

    // Next-state: acquire a reference in SEARCH, flywheel-check against it in LOCKED
    always_comb begin
        state_d     = state_q;
        pred_d      = pred_q;
        has_ref_d   = has_ref_q;
        match_run_d = match_run_q;
        bad_run_d   = bad_run_q;
        err_d       = 1'b0;
        err_cnt_d   = err_cnt_q;
        smp_cnt_d   = smp_cnt_q;
        if (en && state_q == SEARCH) begin
            if (data_in == '0) begin
                has_ref_d   = 1'b0;
                match_run_d = '0;
            end else begin
                pred_d = data_in;
                if (has_ref_q && data_in == exp_w) begin
                    match_run_d = match_run_q + MW'(1);
                    if (match_run_d == MW'(LOCK_MATCHES)) begin
                        state_d     = LOCKED;
                        bad_run_d   = '0;
                        match_run_d = '0;
                    end
                end else begin
                    match_run_d = '0;
                    has_ref_d   = 1'b1;
                end
            end
        end else if (en) begin
            smp_cnt_d = (&smp_cnt_q) ? smp_cnt_q : smp_cnt_q + CNT_W'(1);
            if (data_in == exp_w) begin
                pred_d    = data_in;
                bad_run_d = '0;
            end else begin
                err_d     = 1'b1;
                err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + CNT_W'(1);
                pred_d    = exp_w;
                bad_run_d = bad_run_q + BW'(1);
                if (bad_run_d == BW'(UNLOCK_ERRS)) begin
                    state_d     = SEARCH;
                    has_ref_d   = 1'b0;
                    match_run_d = '0;
                    bad_run_d   = '0;
                end
            end
        end
        if (clr) begin
            err_cnt_d = '0;
            smp_cnt_d = '0;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SEARCH;
            pred_q      <= '0;
            has_ref_q   <= 1'b0;
            match_run_q <= '0;
            bad_run_q   <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            smp_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            pred_q      <= pred_d;
            has_ref_q   <= has_ref_d;
            match_run_q <= match_run_d;
            bad_run_q   <= bad_run_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            smp_cnt_q   <= smp_cnt_d;
        end
    end
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: directed scoreboard bench for lfsr_checker (WIDTH=8)
module tb_lfsr_checker;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [7:0]  data_in = '0;
    logic        clr = 1'b0;
    logic        locked;
    logic        err;
    logic [15:0] err_count;
    logic [15:0] sample_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic        lk;
        logic        er;
        logic [15:0] ec;
        logic [15:0] sc;
    } exp_t;

    exp_t sb[$];

    lfsr_checker dut (
        .clk(clk), .rst(rst), .en(en), .data_in(data_in), .clr(clr),
        .locked(locked), .err(err), .err_count(err_count), .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    task automatic check_out();
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (locked === e.lk) else begin
            errors++;
            $error("FAIL %s locked got %0b exp %0b", e.tag, locked, e.lk);
        end
        checks++;
        assert (err === e.er) else begin
            errors++;
            $error("FAIL %s err got %0b exp %0b", e.tag, err, e.er);
        end
        checks++;
        assert (err_count === e.ec) else begin
            errors++;
            $error("FAIL %s err_count got %0d exp %0d", e.tag, err_count, e.ec);
        end
        checks++;
        assert (sample_count === e.sc) else begin
            errors++;
            $error("FAIL %s sample_count got %0d exp %0d", e.tag, sample_count, e.sc);
        end
    endtask

    task automatic step(input string tag, input logic e_i, input logic [7:0] d, input logic c,
                        input logic lk, input logic er, input int ec, input int sc);
        en = e_i;
        data_in = d;
        clr = c;
        sb.push_back('{tag, lk, er, 16'(ec), 16'(sc)});
        @(posedge clk);
        #1;
        check_out();
        en = 1'b0;
        clr = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        en = 1'b0;
        clr = 1'b0;
        sb.push_back('{tag, 1'b0, 1'b0, 16'd0, 16'd0});
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_out();
    endtask

    task automatic lock_seq(input string tag);
        step({tag, "_01"}, 1, 8'h01, 0, 0, 0, 0, 0);
        step({tag, "_02"}, 1, 8'h02, 0, 0, 0, 0, 0);
        step({tag, "_04"}, 1, 8'h04, 0, 0, 0, 0, 0);
        step({tag, "_08"}, 1, 8'h08, 0, 0, 0, 0, 0);
        step({tag, "_11"}, 1, 8'h11, 0, 1, 0, 0, 0);
    endtask

    initial begin
        do_reset("reset");
        lock_seq("lock");
        step("single_err", 1, 8'h00, 0, 1, 1, 1, 1);
        step("recover_47", 1, 8'h47, 0, 1, 0, 1, 2);
        do_reset("mid_rst");
        lock_seq("lock2");
        step("bad1", 1, 8'hAA, 0, 1, 1, 1, 1);
        step("bad2", 1, 8'hAA, 0, 1, 1, 2, 2);
        step("bad3_unlock", 1, 8'hAA, 0, 0, 1, 3, 3);
        step("search_no_err", 1, 8'hAA, 0, 0, 0, 3, 3);
        do_reset("reset3");
        for (int i = 0; i < 6; i++) step("zeros", 1, 8'h00, 0, 0, 0, 0, 0);
        step("gap_01", 1, 8'h01, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step("gap_en0", 0, 8'h55, 0, 0, 0, 0, 0);
        step("gap_02", 1, 8'h02, 0, 0, 0, 0, 0);
        step("gap_04", 1, 8'h04, 0, 0, 0, 0, 0);
        step("gap_08", 1, 8'h08, 0, 0, 0, 0, 0);
        step("gap_11", 1, 8'h11, 0, 1, 0, 0, 0);
        step("pre_clr_23", 1, 8'h23, 0, 1, 0, 0, 1);
        step("clr_mismatch", 1, 8'h00, 1, 1, 1, 0, 0);
        step("post_clr_err", 1, 8'h00, 0, 1, 1, 1, 1);
        step("fly_8e", 1, 8'hB3, 0, 0, 1, 2, 2);
        step("search_hold", 0, 8'h00, 0, 0, 0, 2, 2);
        do_reset("reset4");
        lock_seq("lock4");
        step("ok_23", 1, 8'h23, 0, 1, 0, 0, 1);
        step("bad_a", 1, 8'h00, 0, 1, 1, 1, 2);
        step("good_8e", 1, 8'h8E, 0, 1, 0, 1, 3);
        step("en0_hold", 0, 8'h00, 0, 1, 0, 1, 3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
